// File: rtl/ram1_ctrl_pkg.sv
// ram1_ctrl_pkg: shared state codes, wait-counter type and strobe levels for the RAM1 data-port controller
package ram1_ctrl_pkg;
  typedef enum logic [2:0] {RC_IDLE, RC_RD, RC_WR, RC_RMW_RD, RC_RMW_WR, RC_ACK} ram_ctrl_state_e;
  typedef logic [3:0] ram_wait_t;
  localparam logic RAM_CHIP_ENABLE = 1'b1;
  localparam logic RAM_CHIP_DISABLE = 1'b0;
  localparam logic RAM_READ_ENABLE = 1'b1;
  localparam logic RAM_WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/ram_byte_merge.sv
// ram_byte_merge: per-byte select between an old word and a new word under byte enables
module ram_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  sel,
  output logic [31:0] merged
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/ram1_ctrl.sv
// ram1_ctrl: req/ack data-port controller for RAM1 with wait states and read-modify-write partial writes
module ram1_ctrl
  import ram1_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_LSB    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stall_req_o,
  output logic        ram_ce_o,
  output logic        ram_re_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);
  ram_ctrl_state_e state;
  ram_wait_t cnt;
  logic [31:0] wdata_q, merge_q, merged;
  logic [3:0] sel_q;
  logic last;
  ram_byte_merge u_merge (
    .old_word(ram_data_i),
    .new_word(wdata_q),
    .sel(sel_q),
    .merged(merged)
  );
  assign last = cnt == ram_wait_t'(WAIT_CYCLES - 1);
  assign stall_req_o = mem_req_i && state != RC_ACK;
  assign ram_data_o = state == RC_RMW_WR ? merge_q : state == RC_WR ? wdata_q : ZERO_WORD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RC_IDLE;
      cnt        <= '0;
      mem_data_o <= ZERO_WORD;
      merge_q    <= ZERO_WORD;
      wdata_q    <= ZERO_WORD;
      sel_q      <= '0;
      mem_ack_o  <= 1'b0;
      ram_ce_o   <= RAM_CHIP_DISABLE;
      ram_re_o   <= ~RAM_READ_ENABLE;
      ram_we_o   <= ~RAM_WRITE_ENABLE;
      ram_addr_o <= ZERO_WORD;
    end else begin
      mem_ack_o <= 1'b0;
      case (state)
        RC_IDLE: if (mem_req_i) begin
          cnt        <= '0;
          wdata_q    <= mem_data_i;
          sel_q      <= mem_sel_i;
          ram_addr_o <= mem_addr_i >> ADDR_LSB;
          if (!mem_we_i) begin
            state    <= RC_RD;
            ram_ce_o <= RAM_CHIP_ENABLE;
            ram_re_o <= RAM_READ_ENABLE;
          end else if (mem_sel_i == 4'hf) begin
            state    <= RC_WR;
            ram_ce_o <= RAM_CHIP_ENABLE;
            ram_we_o <= RAM_WRITE_ENABLE;
          end else if (mem_sel_i == 4'h0) begin
            state     <= RC_ACK;
            mem_ack_o <= 1'b1;
          end else begin
            state    <= RC_RMW_RD;
            ram_ce_o <= RAM_CHIP_ENABLE;
            ram_re_o <= RAM_READ_ENABLE;
          end
        end
        RC_RD: if (last) begin
          mem_data_o <= ram_data_i;
          state      <= RC_ACK;
          mem_ack_o  <= 1'b1;
          ram_ce_o   <= RAM_CHIP_DISABLE;
          ram_re_o   <= ~RAM_READ_ENABLE;
        end else cnt <= cnt + 1'b1;
        RC_RMW_RD: if (last) begin
          merge_q  <= merged;
          cnt      <= '0;
          state    <= RC_RMW_WR;
          ram_re_o <= ~RAM_READ_ENABLE;
          ram_we_o <= RAM_WRITE_ENABLE;
        end else cnt <= cnt + 1'b1;
        RC_WR, RC_RMW_WR: if (last) begin
          state     <= RC_ACK;
          mem_ack_o <= 1'b1;
          ram_ce_o  <= RAM_CHIP_DISABLE;
          ram_we_o  <= ~RAM_WRITE_ENABLE;
        end else cnt <= cnt + 1'b1;
        default: state <= RC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram1_ctrl.sv
// tb_ram1_ctrl: directed scoreboard bench for ram1_ctrl at WAIT_CYCLES 1 and 3 against a fake RAM1
module tb_ram1_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req1 = 1'b0, req3 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] sel = '0;
  logic [31:0] mdo1, mdo3, addr1, addr3, rdo1, rdo3, rdi1, rdi3;
  logic ack1, ack3, st1, st3, ce1, ce3, re1, re3, we1, we3;
  ram1_ctrl #(.WAIT_CYCLES(1), .ADDR_LSB(2)) u1 (
    .clk(clk), .rst(rst), .mem_req_i(req1), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(mdo1), .mem_ack_o(ack1),
    .stall_req_o(st1), .ram_ce_o(ce1), .ram_re_o(re1), .ram_we_o(we1),
    .ram_addr_o(addr1), .ram_data_o(rdo1), .ram_data_i(rdi1)
  );
  ram1_ctrl #(.WAIT_CYCLES(3), .ADDR_LSB(2)) u3 (
    .clk(clk), .rst(rst), .mem_req_i(req3), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(mdo3), .mem_ack_o(ack3),
    .stall_req_o(st3), .ram_ce_o(ce3), .ram_re_o(re3), .ram_we_o(we3),
    .ram_addr_o(addr3), .ram_data_o(rdo3), .ram_data_i(rdi3)
  );
  logic [31:0] m1 [64];
  logic [31:0] m3 [64];
  logic pk_en = 1'b0;
  int pk_idx = 0;
  logic [31:0] pk_val = '0;
  always @(posedge clk) begin
    if (ce1 && we1) m1[addr1[5:0]] = rdo1;
    if (ce3 && we3) m3[addr3[5:0]] = rdo3;
    if (pk_en) begin
      m1[pk_idx] = pk_val;
      m3[pk_idx] = pk_val;
    end
  end
  assign rdi1 = (ce1 && re1) ? m1[addr1[5:0]] : 32'h0;
  assign rdi3 = (ce3 && re3) ? m3[addr3[5:0]] : 32'h0;
  int viol = 0, nack1 = 0, nack3 = 0;
  always @(negedge clk) begin
    if ((re1 && we1) || (ce1 && !(re1 ^ we1)) || (!ce1 && (re1 || we1))) viol++;
    if ((re3 && we3) || (ce3 && !(re3 ^ we3)) || (!ce3 && (re3 || we3))) viol++;
    if (ack1) nack1++;
    if (ack3) nack3++;
  end
  logic cur = 1'b0;
  logic c_ack, c_st, c_ce, c_re, c_we;
  logic [31:0] c_addr, c_mdo;
  assign c_ack  = cur ? ack3 : ack1;
  assign c_st   = cur ? st3 : st1;
  assign c_ce   = cur ? ce3 : ce1;
  assign c_re   = cur ? re3 : re1;
  assign c_we   = cur ? we3 : we1;
  assign c_addr = cur ? addr3 : addr1;
  assign c_mdo  = cur ? mdo3 : mdo1;
  typedef struct {
    string tag;
    int lat;
    int re_c;
    int we_c;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] sh1 [64];
  logic [31:0] sh3 [64];
  logic [31:0] last1 = '0, last3 = '0;
  int nexp1 = 0, nexp3 = 0;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction
  task automatic poke(input int i, input logic [31:0] v);
    pk_idx = i;
    pk_val = v;
    pk_en = 1'b1;
    @(posedge clk);
    #1 pk_en = 1'b0;
    sh1[i] = v;
    sh3[i] = v;
  endtask
  task automatic access(input logic d, input logic w_, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic b2b, input string tag);
    int w, cyc, rc, wc, cc, sbad, abad, idx;
    logic to;
    logic [31:0] old;
    exp_t e, g;
    w = d ? 3 : 1;
    cyc = 0; rc = 0; wc = 0; cc = 0; sbad = 0; abad = 0; to = 1'b1;
    idx = int'(a[7:2]);
    e.tag = tag;
    e.lat = ((w_ && s == 4'h0) ? 1 : (w_ && s != 4'hf) ? 2 * w + 1 : w + 1) + (b2b ? 1 : 0);
    e.re_c = (!w_ || (s != 4'h0 && s != 4'hf)) ? w : 0;
    e.we_c = (w_ && s != 4'h0) ? w : 0;
    old = d ? sh3[idx] : sh1[idx];
    if (!w_) begin
      e.rd = old;
      if (d) last3 = old; else last1 = old;
    end else begin
      e.rd = d ? last3 : last1;
      if (s != 4'h0) begin
        if (d) sh3[idx] = mrg(old, wd, s); else sh1[idx] = mrg(old, wd, s);
      end
    end
    if (d) nexp3++; else nexp1++;
    sbq.push_back(e);
    cur = d; we = w_; addr = a; sel = s; wdata = wd; req1 = !d; req3 = d;
    #1 if (c_st !== !b2b) sbad++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (c_re) rc++;
      if (c_we) wc++;
      if (c_ce) begin
        cc++;
        if (c_addr !== (a >> 2)) abad++;
      end
      if (c_st !== !c_ack) sbad++;
      if (c_ack) begin
        to = 1'b0;
        break;
      end
    end
    g = sbq.pop_front();
    chk({g.tag, "_timeout"}, 32'(to), 32'h0);
    chk({g.tag, "_latency"}, cyc, g.lat);
    chk({g.tag, "_re_cycles"}, rc, g.re_c);
    chk({g.tag, "_we_cycles"}, wc, g.we_c);
    chk({g.tag, "_ce_cycles"}, cc, g.re_c + g.we_c);
    chk({g.tag, "_rdata"}, c_mdo, g.rd);
    chk({g.tag, "_stall_bad"}, sbad, 0);
    chk({g.tag, "_addr_bad"}, abad, 0);
  endtask
  task automatic idle();
    req1 = 1'b0;
    req3 = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int mm;
    for (int i = 0; i < 64; i++) poke(i, 32'(i) * 32'h01010101 ^ 32'h5a000000);
    poke(4, 32'hdeadbeef);
    poke(2, 32'haabbccdd);
    @(negedge clk);
    chk("rst_ack", ack1, 0);
    chk("rst_stall", st1, 0);
    chk("rst_ce", ce1, 0);
    chk("rst_re", re1, 0);
    chk("rst_we", we1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wdata", rdo1, 0);
    chk("rst_rdata", mdo1, 0);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b0, 32'h10, 4'hf, 32'h0, 1'b0, "w1_rd");
    idle();
    access(1'b1, 1'b1, 32'h20, 4'hf, 32'h12345678, 1'b0, "w3_wr");
    idle();
    access(1'b1, 1'b0, 32'h20, 4'hf, 32'h0, 1'b0, "w3_rd");
    idle();
    access(1'b0, 1'b1, 32'h8, 4'b0101, 32'h11223344, 1'b0, "rmw");
    idle();
    chk("rmw_word", m1[2], 32'haa22cc44);
    access(1'b0, 1'b1, 32'h10, 4'h0, 32'hffffffff, 1'b0, "sel0");
    idle();
    chk("sel0_unchanged", m1[4], 32'hdeadbeef);
    access(1'b0, 1'b0, 32'h8, 4'hf, 32'h0, 1'b0, "b2b_rd0");
    access(1'b0, 1'b0, 32'h13, 4'hf, 32'h0, 1'b1, "b2b_rd1");
    access(1'b0, 1'b1, 32'h30, 4'hf, 32'hcafef00d, 1'b1, "b2b_wr");
    idle();
    chk("b2b_ack_count", nack1, nexp1);
    cur = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hf; wdata = 32'h55aa55aa; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ph1_we", we3, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ph2_we", we3, 1);
    rst = 1'b1;
    req3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", we3, 0);
    chk("mid_rst_ce", ce3, 0);
    chk("mid_rst_ack", ack3, 0);
    chk("mid_rst_addr", addr3, 0);
    chk("mid_rst_wdata", rdo3, 0);
    chk("mid_rst_rdata", mdo3, 0);
    rst = 1'b0;
    sh3[16] = 32'h55aa55aa;
    last1 = '0;
    last3 = '0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_ack", nack3, nexp3);
    access(1'b1, 1'b0, 32'h20, 4'hf, 32'h0, 1'b0, "post_rst_rd");
    idle();
    repeat (2) @(negedge clk);
    chk("strobe_viol", viol, 0);
    chk("ack_count1", nack1, nexp1);
    chk("ack_count3", nack3, nexp3);
    mm = 0;
    for (int i = 0; i < 64; i++) if (m1[i] !== sh1[i] || m3[i] !== sh3[i]) mm++;
    chk("ram_contents", mm, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
